bus_master_seq: RTL and testbench
=================================

# bus_master_seq

Master-side sequencer for the 32-bit handshaked peripheral bus. It accepts one transaction request at a time from an internal requester, such as the command interpreter or a test harness, and selects the target subsystem with a one-hot enable. It then runs the full two-wire handshake: command word out, data word in, and an optional status word in. It returns the captured words, or a timeout error, on a response interface. The block sits between the requester and the shared bus that fans out to every subsystem's slave-side bus FSM.

## Interface
Parameters:
- NUM_SUBSYSTEMS, 4: number of slave subsystems; width of the enable vector.
- TIMEOUT_CYCLES, 1023: maximum cycles spent in any single wait state before abort; must be ≥ 2.
- STATUS_RETURN, 1: 1 = the slaves return a status word after the data word; 0 = data word only.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and accepting; a transfer occurs when req_valid && req_ready.
- req_subsystem  in  $clog2(NUM_SUBSYSTEMS)  target subsystem index.
- req_rw  in  1  RW line value for the transaction.
- req_word  in  32  command word driven onto the bus.
- resp_valid  out  1  one-cycle pulse: transaction finished.
- resp_data  out  32  captured data word.
- resp_status  out  32  captured status word; 0 when STATUS_RETURN=0.
- resp_error  out  1  valid with resp_valid; 1 = timeout abort.
- subsystem_enable  out  NUM_SUBSYSTEMS  one-hot; all zero when idle.
- RW  out  1  latched req_rw.
- handshake_1  out  1  master strobe.
- handshake_2  in  1  slave acknowledge; sampled only while an enable is asserted.
- bus_out  out  32  word driven by the master.
- bus_drive  out  1  master owns the bus (tristate enable).
- bus_in  in  32  bus value as read back.

## Operation
All outputs are registered. Reset values: req_ready=1, all other outputs 0. States, held in an enum:
- IDLE: req_ready=1. On transfer, latch subsystem, rw and word, then go to CMD_SETUP.
- CMD_SETUP: enable[idx]=1, RW, bus_drive=1, bus_out=word, handshake_1=0. Go to CMD_STROBE after one cycle, which gives one cycle of setup before the strobe.
- CMD_STROBE: handshake_1=1. Wait for handshake_2=1, then go to CMD_RELEASE.
- CMD_RELEASE: handshake_1=0, bus_drive=0. Wait for handshake_2=0, then go to DATA_WAIT.
- DATA_WAIT: wait for handshake_2=1. On that cycle, capture bus_in into resp_data and go to DATA_ACK.
- DATA_ACK: handshake_1=1. Wait for handshake_2=0, then go to DATA_DONE.
- DATA_DONE: handshake_1=0. Go to STATUS_WAIT if STATUS_RETURN, else to FINISH.
- STATUS_WAIT: same as DATA_WAIT, but capture into resp_status.
- STATUS_ACK: same as DATA_ACK, but the exit goes to STATUS_DONE.
- STATUS_DONE: handshake_1=0. Go to FINISH.
- FINISH: enable all zero. Pulse resp_valid with resp_error=0. Go to IDLE.
- ABORT: entered from any wait state on timeout. handshake_1=0, bus_drive=0, enable all zero. Pulse resp_valid with resp_error=1. Go to IDLE. The target slave is left mid-sequence and the requester must reset it.

Other rules:
- req_subsystem ≥ NUM_SUBSYSTEMS: accepted but not issued. Next cycle: resp_valid=1, resp_error=1, no enable asserted.
- resp_data and resp_status hold their values until the next capture. They are not cleared on abort.
- bus_drive and handshake_1 are never both low while the command word is still needed. bus_drive falls in the same cycle handshake_1 falls.

## Timing
- Request to enable assertion: 1 cycle. Enable to first handshake_1 rise: 1 cycle.
- Every handshake_2 edge is responded to on the next clock edge, giving one cycle of latency per edge.
- Timeout counter clears on each state entry. It increments every cycle spent in a wait state. When the count reaches TIMEOUT_CYCLES, the block goes to ABORT.
- A new request is accepted no sooner than the cycle after resp_valid. Back-to-back transactions therefore have enable low for at least 1 cycle, which the slave's final state requires.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous), no response is issued, and the state goes to IDLE.

## Structure
- bus_master_pkg:
  - state enum.
  - BUS_WIDTH=32.
  - timeout width function.
- Sub-module bus_timeout_counter:
  - Parameter LIMIT.
  - Inputs clear and run.
  - Output expired.
- The FSM uses three-section Moore style: state register, next-state logic, registered outputs.

## Test plan
- Slave model that responds with a 2-cycle delay on every edge. Request subsystem 2, rw=1, word 0x0000_1234; slave returns data 0xCAFE_F00D and status 0x0000_0001 → enable=4'b0100 during the transaction, resp_data=0xCAFE_F00D, resp_status=1, resp_error=0, and the enable sequence has exactly one rising and one falling edge.
- STATUS_RETURN=0, request subsystem 0 with data 0xA5A5_A5A5 → resp_valid arrives after the data phase with resp_status=0, and handshake_1 rises exactly twice.
- Slave never raises handshake_2, TIMEOUT_CYCLES=15 → ABORT is reached exactly 15 cycles after entering CMD_STROBE, resp_error=1, all outputs except req_ready are 0.
- req_subsystem=5 with NUM_SUBSYSTEMS=4 → the next cycle gives resp_valid=1 and resp_error=1, and subsystem_enable stays 0 throughout.
- Two back-to-back requests held on req_valid → enable is low for ≥1 cycle between them, and the second command word appears on bus_out only after the first resp_valid.
- Reset pulsed while in DATA_WAIT → handshake_1, bus_drive, enable and resp_valid are 0 within the same cycle, and req_ready=1 after reset is released.

Source files
------------

// File: rtl/bus_master_pkg.sv
// Shared types and helpers for the bus master sequencer.
package bus_master_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    typedef enum logic [3:0] {
        StIdle,
        StCmdSetup,
        StCmdStrobe,
        StCmdRelease,
        StDataWait,
        StDataAck,
        StDataDone,
        StStatusWait,
        StStatusAck,
        StStatusDone,
        StFinish,
        StAbort
    } state_e;

    // Counter only needs to reach limit-1 before the abort fires.
    function automatic int unsigned timeout_width(input int unsigned limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-state wait counter; expired is high on the LIMIT-th cycle spent waiting.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    import bus_master_pkg::*;

    localparam int unsigned CW = timeout_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = run && (r_count == LAST);

endmodule

// File: rtl/bus_master_seq.sv
// Master-side sequencer: issues one command/data/status handshake per request.
module bus_master_seq #(
    parameter int unsigned NUM_SUBSYSTEMS = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          STATUS_RETURN  = 1'b1,
    localparam int unsigned IDX_W = (NUM_SUBSYSTEMS > 1) ? $clog2(NUM_SUBSYSTEMS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [IDX_W-1:0]          req_subsystem,
    input  logic                      req_rw,
    input  logic [31:0]               req_word,
    output logic                      resp_valid,
    output logic [31:0]               resp_data,
    output logic [31:0]               resp_status,
    output logic                      resp_error,
    output logic [NUM_SUBSYSTEMS-1:0] subsystem_enable,
    output logic                      RW,
    output logic                      handshake_1,
    input  logic                      handshake_2,
    output logic [31:0]               bus_out,
    output logic                      bus_drive,
    input  logic [31:0]               bus_in
);
    import bus_master_pkg::*;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_rw;
    logic [BUS_WIDTH-1:0]     r_word;

    logic                     w_idx_ok;
    logic                     w_in_wait;
    logic                     w_state_change;
    logic                     w_expired;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_rw;
    logic [BUS_WIDTH-1:0]     w_word;
    logic                     w_active;
    logic                     w_drive;
    logic                     w_strobe;
    logic [NUM_SUBSYSTEMS-1:0] w_enable;

    assign w_idx_ok       = 32'(req_subsystem) < NUM_SUBSYSTEMS;
    assign w_in_wait      = r_state inside {StCmdStrobe, StCmdRelease, StDataWait, StDataAck,
                                            StStatusWait, StStatusAck};
    assign w_state_change = (w_state_next != r_state);

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_state_change),
        .run     (w_in_wait),
        .expired (w_expired)
    );

    // Next-state logic; a handshake edge takes priority over a same-cycle timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:       if (req_valid) w_state_next = w_idx_ok ? StCmdSetup : StAbort;
            StCmdSetup:   w_state_next = StCmdStrobe;
            StCmdStrobe:  if (handshake_2) w_state_next = StCmdRelease;
                          else if (w_expired) w_state_next = StAbort;
            StCmdRelease: if (!handshake_2) w_state_next = StDataWait;
                          else if (w_expired) w_state_next = StAbort;
            StDataWait:   if (handshake_2) w_state_next = StDataAck;
                          else if (w_expired) w_state_next = StAbort;
            StDataAck:    if (!handshake_2) w_state_next = StDataDone;
                          else if (w_expired) w_state_next = StAbort;
            StDataDone:   w_state_next = STATUS_RETURN ? StStatusWait : StFinish;
            StStatusWait: if (handshake_2) w_state_next = StStatusAck;
                          else if (w_expired) w_state_next = StAbort;
            StStatusAck:  if (!handshake_2) w_state_next = StStatusDone;
                          else if (w_expired) w_state_next = StAbort;
            StStatusDone: w_state_next = StFinish;
            default:      w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        w_idx    = (r_state == StIdle) ? req_subsystem : r_idx;
        w_rw     = (r_state == StIdle) ? req_rw : r_rw;
        w_word   = (r_state == StIdle) ? req_word : r_word;
        w_active = w_state_next inside {StCmdSetup, StCmdStrobe, StCmdRelease, StDataWait,
                                        StDataAck, StDataDone, StStatusWait, StStatusAck,
                                        StStatusDone};
        w_drive  = w_state_next inside {StCmdSetup, StCmdStrobe};
        w_strobe = w_state_next inside {StCmdStrobe, StDataAck, StStatusAck};
        w_enable = '0;
        if (w_active) begin
            w_enable[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= StIdle;
            r_idx            <= '0;
            r_rw             <= 1'b0;
            r_word           <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_data        <= '0;
            resp_status      <= '0;
            subsystem_enable <= '0;
            RW               <= 1'b0;
            handshake_1      <= 1'b0;
            bus_out          <= '0;
            bus_drive        <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            req_ready        <= (w_state_next == StIdle);
            resp_valid       <= (w_state_next == StFinish) || (w_state_next == StAbort);
            resp_error       <= (w_state_next == StAbort);
            subsystem_enable <= w_enable;
            RW               <= w_active && w_rw;
            handshake_1      <= w_strobe;
            bus_drive        <= w_drive;
            bus_out          <= w_drive ? w_word : '0;
            if (r_state == StIdle && req_valid) begin
                r_idx  <= req_subsystem;
                r_rw   <= req_rw;
                r_word <= req_word;
            end
            if (r_state == StDataWait && handshake_2) begin
                resp_data <= bus_in;
            end
            if (STATUS_RETURN && r_state == StStatusWait && handshake_2) begin
                resp_status <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench: two sequencer instances, each driven against a clocked slave model.
module tb_bus_master_seq;

    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 4 subsystems, status word returned
    logic        a_req_valid, a_req_ready, a_req_rw;
    logic [1:0]  a_req_sub;
    logic [31:0] a_req_word, a_resp_data, a_resp_status, a_bus_out, a_bus_in;
    logic        a_resp_valid, a_resp_error, a_rw, a_hs1, a_hs2, a_drive;
    logic [3:0]  a_en;

    // Instance B: 6 subsystems, data word only
    logic        b_req_valid, b_req_ready, b_req_rw;
    logic [2:0]  b_req_sub;
    logic [31:0] b_req_word, b_resp_data, b_resp_status, b_bus_out, b_bus_in;
    logic        b_resp_valid, b_resp_error, b_rw, b_hs1, b_hs2, b_drive;
    logic [5:0]  b_en;

    bus_master_seq #(
        .NUM_SUBSYSTEMS (4),
        .TIMEOUT_CYCLES (TO),
        .STATUS_RETURN  (1'b1)
    ) dut_a (
        .clk (clk), .reset (rst_n),
        .req_valid (a_req_valid), .req_ready (a_req_ready), .req_subsystem (a_req_sub),
        .req_rw (a_req_rw), .req_word (a_req_word),
        .resp_valid (a_resp_valid), .resp_data (a_resp_data), .resp_status (a_resp_status),
        .resp_error (a_resp_error), .subsystem_enable (a_en), .RW (a_rw),
        .handshake_1 (a_hs1), .handshake_2 (a_hs2),
        .bus_out (a_bus_out), .bus_drive (a_drive), .bus_in (a_bus_in)
    );

    bus_master_seq #(
        .NUM_SUBSYSTEMS (6),
        .TIMEOUT_CYCLES (TO),
        .STATUS_RETURN  (1'b0)
    ) dut_b (
        .clk (clk), .reset (rst_n),
        .req_valid (b_req_valid), .req_ready (b_req_ready), .req_subsystem (b_req_sub),
        .req_rw (b_req_rw), .req_word (b_req_word),
        .resp_valid (b_resp_valid), .resp_data (b_resp_data), .resp_status (b_resp_status),
        .resp_error (b_resp_error), .subsystem_enable (b_en), .RW (b_rw),
        .handshake_1 (b_hs1), .handshake_2 (b_hs2),
        .bus_out (b_bus_out), .bus_drive (b_drive), .bus_in (b_bus_in)
    );

    // Slave models: each reaction lands two negedges after the edge that triggered it
    logic        sv_en [2];
    logic        sv_hs1 [2];
    logic        sv_hs2 [2];
    logic [31:0] sv_bus [2];
    logic        sl_silent [2];
    logic [31:0] sl_data [2];
    logic [31:0] sl_stat [2];
    int          sl_st [2];
    int          sl_cnt [2];

    assign sv_en[0]  = |a_en;
    assign sv_en[1]  = |b_en;
    assign sv_hs1[0] = a_hs1;
    assign sv_hs1[1] = b_hs1;
    assign a_hs2     = sv_hs2[0];
    assign b_hs2     = sv_hs2[1];
    assign a_bus_in  = sv_bus[0];
    assign b_bus_in  = sv_bus[1];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                sl_st[k]  <= 0;
                sl_cnt[k] <= 0;
                sv_hs2[k] <= 1'b0;
                sv_bus[k] <= '0;
            end else if (sl_cnt[k] != 0) begin
                sl_cnt[k] <= sl_cnt[k] - 1;
            end else begin
                case (sl_st[k])
                    0:  if (sv_en[k] && sv_hs1[k] && !sl_silent[k]) begin
                            sl_st[k] <= 1; sl_cnt[k] <= 1;
                        end
                    1:  begin sv_hs2[k] <= 1'b1; sl_st[k] <= 2; end
                    2:  if (!sv_hs1[k]) begin sl_st[k] <= 3; sl_cnt[k] <= 1; end
                    3:  begin sv_hs2[k] <= 1'b0; sl_st[k] <= 4; sl_cnt[k] <= 1; end
                    4:  begin sv_bus[k] <= sl_data[k]; sv_hs2[k] <= 1'b1; sl_st[k] <= 5; end
                    5:  if (sv_hs1[k]) begin sl_st[k] <= 6; sl_cnt[k] <= 1; end
                    6:  begin sv_hs2[k] <= 1'b0; sl_st[k] <= (k == 0) ? 7 : 11; end
                    7:  if (!sv_hs1[k]) begin sl_st[k] <= 8; sl_cnt[k] <= 1; end
                    8:  begin sv_bus[k] <= sl_stat[k]; sv_hs2[k] <= 1'b1; sl_st[k] <= 9; end
                    9:  if (sv_hs1[k]) begin sl_st[k] <= 10; sl_cnt[k] <= 1; end
                    10: begin sv_hs2[k] <= 1'b0; sl_st[k] <= 11; end
                    11: if (!sv_en[k]) sl_st[k] <= 0;
                    default: sl_st[k] <= 0;
                endcase
            end
        end
    end

    // Per-transaction observation, restarted on every accepted request
    logic        a_acc_q, b_acc_q, a_en_prev, b_hs1_prev, a_rw_seen;
    logic [3:0]  a_en_seen;
    logic [5:0]  b_en_seen;
    logic [31:0] a_cmd_seen;
    int          a_en_rise, a_en_fall, b_hs1_rise;

    always @(posedge clk) begin
        a_acc_q <= a_req_valid && a_req_ready;
        b_acc_q <= b_req_valid && b_req_ready;
    end

    always @(negedge clk) begin
        a_en_prev  <= |a_en;
        b_hs1_prev <= b_hs1;
        a_en_seen  <= (a_acc_q ? 4'b0 : a_en_seen) | a_en;
        b_en_seen  <= (b_acc_q ? 6'b0 : b_en_seen) | b_en;
        a_rw_seen  <= (a_acc_q ? 1'b0 : a_rw_seen) | a_rw;
        a_en_rise  <= (a_acc_q ? 0 : a_en_rise) + (((|a_en) && !a_en_prev) ? 1 : 0);
        a_en_fall  <= (a_acc_q ? 0 : a_en_fall) + ((!(|a_en) && a_en_prev) ? 1 : 0);
        b_hs1_rise <= (b_acc_q ? 0 : b_hs1_rise) + ((b_hs1 && !b_hs1_prev) ? 1 : 0);
        if (a_hs1 && a_drive) a_cmd_seen <= a_bus_out;
        else if (a_acc_q)     a_cmd_seen <= '0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_a(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            a_req_valid = 1'b0;
        end while (!a_resp_valid && cyc < 200);
        chk("a_resp_arrived", a_resp_valid, 1);
    endtask

    typedef struct packed {
        logic [1:0]  sub;
        logic        rw;
        logic [31:0] word;
        logic [31:0] data;
        logic [31:0] stat;
        logic [3:0]  en;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int   cyc;
        logic early;

        vecs[0] = '{2'd2, 1'b1, 32'h0000_1234, 32'hCAFE_F00D, 32'h0000_0001, 4'b0100};
        vecs[1] = '{2'd0, 1'b0, 32'hDEAD_0001, 32'h1234_5678, 32'h8000_0000, 4'b0001};
        vecs[2] = '{2'd3, 1'b1, 32'h0F0F_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000};
        vecs[3] = '{2'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 4'b0010};

        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_sub = '0; a_req_rw = 1'b0; a_req_word = '0;
        b_req_valid = 1'b0; b_req_sub = '0; b_req_rw = 1'b0; b_req_word = '0;
        for (int k = 0; k < 2; k++) begin
            sl_silent[k] = 1'b0; sl_data[k] = '0; sl_stat[k] = '0;
        end
        repeat (3) @(negedge clk);

        chk("rst_a_ready", a_req_ready, 1);
        chk("rst_a_ctrl", {a_resp_valid, a_resp_error, a_en, a_rw, a_hs1, a_drive}, 0);
        chk("rst_a_words", a_bus_out | a_resp_data | a_resp_status, 0);
        chk("rst_b_ready", b_req_ready, 1);
        chk("rst_b_ctrl", {b_resp_valid, b_resp_error, b_en, b_rw, b_hs1, b_drive}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full transactions on instance A
        for (int i = 0; i < 4; i++) begin
            sl_data[0] = vecs[i].data;
            sl_stat[0] = vecs[i].stat;
            a_req_sub = vecs[i].sub; a_req_rw = vecs[i].rw; a_req_word = vecs[i].word;
            a_req_valid = 1'b1;
            @(negedge clk);
            a_req_valid = 1'b0;
            chk($sformatf("v%0d_setup_en", i), a_en, vecs[i].en);
            chk($sformatf("v%0d_setup_bus", i), {a_drive, a_hs1, a_bus_out},
                {1'b1, 1'b0, vecs[i].word});
            @(negedge clk);
            chk($sformatf("v%0d_strobe", i), a_hs1, 1);
            wait_a(cyc);
            chk($sformatf("v%0d_error", i), a_resp_error, 0);
            chk($sformatf("v%0d_data", i), a_resp_data, vecs[i].data);
            chk($sformatf("v%0d_status", i), a_resp_status, vecs[i].stat);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {a_req_ready, a_resp_valid}, 2'b10);
            chk($sformatf("v%0d_en_seen", i), a_en_seen, vecs[i].en);
            chk($sformatf("v%0d_en_edges", i), {a_en_rise[7:0], a_en_fall[7:0]}, 16'h0101);
            chk($sformatf("v%0d_cmd", i), a_cmd_seen, vecs[i].word);
            chk($sformatf("v%0d_rw", i), a_rw_seen, vecs[i].rw);
        end

        // Timeout: silent slave, abort lands TO cycles after entering the strobe state
        sl_silent[0] = 1'b1;
        @(negedge clk);
        a_req_sub = 2'd1; a_req_rw = 1'b1; a_req_word = 32'h5555_AAAA;
        a_req_valid = 1'b1;
        wait_a(cyc);
        chk("to_latency", cyc, 2 + TO);
        chk("to_error", a_resp_error, 1);
        chk("to_ctrl", {a_req_ready, a_en, a_rw, a_hs1, a_drive}, 0);
        chk("to_bus_out", a_bus_out, 0);
        chk("to_data_held", a_resp_data, vecs[3].data);
        chk("to_status_held", a_resp_status, vecs[3].stat);
        @(negedge clk);
        chk("to_idle", {a_req_ready, a_resp_valid, a_resp_error}, 3'b100);
        sl_silent[0] = 1'b0;
        @(negedge clk);

        // Back-to-back requests with req_valid held high
        sl_data[0] = 32'h0BAD_0001; sl_stat[0] = 32'h0000_0002;
        a_req_sub = 2'd1; a_req_rw = 1'b0; a_req_word = 32'h1111_0001;
        a_req_valid = 1'b1;
        @(negedge clk);
        a_req_sub = 2'd3; a_req_rw = 1'b1; a_req_word = 32'h2222_0002;
        cyc = 0;
        early = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (a_bus_out == 32'h2222_0002) early = 1'b1;
        end while (!a_resp_valid && cyc < 200);
        chk("b2b_first_resp", a_resp_valid, 1);
        chk("b2b_first_data", a_resp_data, 32'h0BAD_0001);
        chk("b2b_no_early_word", early, 0);
        @(negedge clk);
        chk("b2b_gap", {a_req_ready, a_en}, 5'b1_0000);
        @(negedge clk);
        a_req_valid = 1'b0;
        chk("b2b_second_en", a_en, 4'b1000);
        chk("b2b_second_word", a_bus_out, 32'h2222_0002);
        wait_a(cyc);
        chk("b2b_second_status", a_resp_status, 32'h0000_0002);

        // Reset while waiting for the data word
        @(negedge clk);
        sl_data[0] = 32'h7777_7777;
        a_req_sub = 2'd2; a_req_rw = 1'b1; a_req_word = 32'h0000_0042;
        a_req_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            a_req_valid = 1'b0;
        end while (sl_st[0] != 4 && cyc < 100);
        chk("rst_mid_reached", a_en, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {a_en, a_hs1, a_drive, a_resp_valid}, 0);
        chk("rst_mid_ready", a_req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_resp_valid) early = 1'b1;
        end
        chk("rst_mid_no_resp", early, 0);
        chk("rst_mid_ready_after", a_req_ready, 1);

        // Instance B: data-only handshake
        sl_data[1] = 32'hA5A5_A5A5;
        b_req_sub = 3'd0; b_req_rw = 1'b0; b_req_word = 32'h0000_5A5A;
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("b_en", b_en, 6'b000001);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!b_resp_valid && cyc < 200);
        chk("b_resp_arrived", b_resp_valid, 1);
        chk("b_data", b_resp_data, 32'hA5A5_A5A5);
        chk("b_status_zero", b_resp_status, 0);
        chk("b_error", b_resp_error, 0);
        @(negedge clk);
        chk("b_hs1_rises", b_hs1_rise, 2);
        chk("b_en_seen", b_en_seen, 6'b000001);

        // Instance B: out-of-range subsystem is answered with an error next cycle
        b_req_sub = 3'd6; b_req_word = 32'h0000_0666;
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("bad_idx_resp", {b_resp_valid, b_resp_error}, 2'b11);
        chk("bad_idx_en", b_en, 0);
        @(negedge clk);
        chk("bad_idx_en_seen", b_en_seen, 0);
        chk("bad_idx_idle", {b_req_ready, b_resp_valid}, 2'b10);
        chk("bad_idx_data_held", b_resp_data, 32'hA5A5_A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
